prbs9_checker: RTL and testbench
================================

# prbs9_checker

Serial receive-side checker for the 9-stage pseudo-random bit stream produced by the team's LFSR generator. It synchronises itself to the incoming stream, declares lock and counts bit errors once locked. The error count is also encoded onto two 7-segment digits, matching the generator's display. It sits at the far end of the link from the generator: the stream is fed in one bit per valid cycle.

## Interface
- `LOCK_THRESH`, default 16: consecutive correct predictions needed to declare lock (range 1..255).
- `LOSS_THRESH`, default 4: consecutive mispredictions while locked that drop lock (range 1..15).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_bit` in 1: received stream bit.
- `in_valid` in 1: `in_bit` is meaningful this cycle; no action when low.
- `clr_err` in 1: synchronous clear of `err_cnt`.
- `locked` out 1: checker is synchronised.
- `bit_err` out 1: one-cycle pulse per counted error.
- `err_cnt` out 8: saturating error count.
- `hex_high` out 7: 7-segment code for `err_cnt[7:4]`. Active-low; bit0 = segment a … bit6 = segment g.
- `hex_low` out 7: 7-segment code for `err_cnt[3:0]`, same encoding.

## Operation
- Stream law: s[n+9] = s[n] ^ s[n+2] ^ s[n+3] ^ s[n+4], with s[n] the n-th valid bit.
- `hist[8:0]` holds the last 9 valid bits, with `hist[0]` the oldest. `pred = hist[0]^hist[2]^hist[3]^hist[4]`.
- On each valid bit, history shifts toward index 0; the new entry enters at `hist[8]`.
- The FSM has three states: FILL, SEARCH and LOCK.
- **FILL**
  - Each valid bit shifts `in_bit` into history and increments `fill_cnt`.
  - After the 9th valid bit, go to SEARCH.
- **SEARCH** (history is self-synchronising, so `in_bit` is shifted in)
  - `in_bit == pred` with history not all-zero: `good_cnt++`.
  - Mismatch, or history all-zero: `good_cnt <= 0`.
  - When a match brings `good_cnt` to `LOCK_THRESH`, go to LOCK and clear `good_cnt`.
  - No errors are counted in SEARCH.
- **LOCK** (free-running reference: `pred` is shifted in, not `in_bit`, so one flipped bit counts once)
  - Mismatch: `bit_err` pulses, `err_cnt` increments (saturates at 255) and `bad_run++`.
  - Match: `bad_run <= 0`.
  - When `bad_run` reaches `LOSS_THRESH`, go to SEARCH and clear `bad_run`. History keeps its content.
- **clr_err**: `err_cnt <= 0`, taking priority over an increment in the same cycle. `bit_err` still pulses in that case.
- **Reset values**
  - State FILL; `hist`, `fill_cnt`, `good_cnt`, `bad_run` are 0.
  - `locked` = 0, `bit_err` = 0, `err_cnt` = 0.
  - `hex_high` = `hex_low` = 7'b1000000 (digit 0).
- Reset asserted mid-operation returns everything to these values immediately (asynchronous), regardless of state.
- **Hex map** (0..F, active-low, gfedcba): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.

## Timing
- All outputs are registered.
- `locked` rises on the clock edge that accepts the `LOCK_THRESH`-th consecutive matching bit, and is visible the following cycle.
- `locked` falls on the edge accepting the `LOSS_THRESH`-th consecutive mismatch.
- `bit_err` and `err_cnt` update on the edge that accepts the erroneous bit. That is one-cycle latency from the input cycle.
- Hex outputs are combinational decodes of registered `err_cnt`, so they change in the same cycle as `err_cnt`.
- Cycles with `in_valid` = 0 freeze all state, including match and mismatch runs.
- Minimum time to lock from reset: 9 + `LOCK_THRESH` valid bits.

## Configuration
- `PRBS9_CHECKER_HEX_EN` defined: the hex decoders are built and `hex_high`/`hex_low` follow `err_cnt`.
- Not defined: decoders are omitted and `hex_high` = `hex_low` = 7'h7F (all segments off) permanently. All other behaviour is identical.

## Test plan
- Seed s[0..8] = 1,0,0,0,0,0,0,0,0, clean stream, `in_valid` always 1 → `locked` = 1 from the cycle after bit 25 onward; `err_cnt` stays 0; hex shows 40/40.
- Locked; invert a single bit at n = 40 → exactly one `bit_err` pulse and `err_cnt` = 1. `locked` stays 1 and `hex_low` = 79.
- Locked; invert 4 consecutive bits → `err_cnt` = 4 and `locked` drops after the 4th. With a clean stream, relock occurs 16 valid bits later.
- All-zero stream for 100 bits → `locked` never asserts and `err_cnt` = 0.
- Force 300 errors in LOCK by repeated 3-bit bursts separated by clean bits → `err_cnt` saturates at 255 (hex F/F = 0E/0E). Then `clr_err` with a simultaneous error → `err_cnt` = 0 and `bit_err` = 1.
- Gap `in_valid` low every other cycle during lock-up → lock at the 25th valid bit, not the 25th cycle. Asserting `reset` mid-LOCK → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/prbs9_checker.sv
// prbs9_checker: receive-side checker for a 9-stage PRBS (s[n+9] = s[n]^s[n+2]^s[n+3]^s[n+4]).
// Fills a 9-bit history, searches for a run of correct predictions, then locks and
// counts bit errors against a free-running reference. The error count is shown on two
// active-low 7-segment digits when PRBS9_CHECKER_HEX_EN is defined; otherwise both
// digits are held blank (7'h7F).
// Handshake: a bit is consumed on every rising edge where in_valid is high; when
// in_valid is low all state (including match/mismatch runs) holds.
module prbs9_checker #(
  parameter int unsigned LOCK_THRESH = 16,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       clr_err,
  output logic       locked,
  output logic       bit_err,
  output logic [7:0] err_cnt,
  output logic [6:0] hex_high,
  output logic [6:0] hex_low,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

  localparam logic [7:0] LOCK_T = 8'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  logic [1:0] state_q,    state_d;
  logic [8:0] hist_q,     hist_d;
  logic [3:0] fill_cnt_q, fill_cnt_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [3:0] bad_run_q,  bad_run_d;
  logic       locked_q,   locked_d;
  logic       bit_err_q,  bit_err_d;
  logic [7:0] err_cnt_q,  err_cnt_d;

  logic pred;
  logic hist_nz;

  // hist_q[0] is the oldest bit, so the prediction taps follow the stream law directly
  assign pred    = hist_q[0] ^ hist_q[2] ^ hist_q[3] ^ hist_q[4];
  assign hist_nz = |hist_q;

  // Next-state logic for the FILL / SEARCH / LOCK sequence and the error counter
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_cnt_d = fill_cnt_q;
    good_cnt_d = good_cnt_q;
    bad_run_d  = bad_run_q;
    locked_d   = locked_q;
    bit_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (in_valid) begin
      case (state_q)
        ST_FILL: begin
          hist_d     = {in_bit, hist_q[8:1]};
          fill_cnt_d = fill_cnt_q + 4'd1;
          if (fill_cnt_q == 4'd8) state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          // Received bits feed the history so it resynchronises to the stream
          hist_d = {in_bit, hist_q[8:1]};
          if ((in_bit == pred) && hist_nz) begin
            if (good_cnt_q + 8'd1 == LOCK_T) begin
              state_d    = ST_LOCK;
              good_cnt_d = 8'd0;
              locked_d   = 1'b1;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            good_cnt_d = 8'd0;
          end
        end
        ST_LOCK: begin
          // Reference runs free so a single flipped bit is counted exactly once
          hist_d = {pred, hist_q[8:1]};
          if (in_bit != pred) begin
            bit_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (bad_run_q + 4'd1 == LOSS_T) begin
              state_d   = ST_SEARCH;
              bad_run_d = 4'd0;
              locked_d  = 1'b0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end else begin
            bad_run_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; the error pulse is still reported
    if (clr_err) err_cnt_d = 8'd0;
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      hist_q     <= 9'd0;
      fill_cnt_q <= 4'd0;
      good_cnt_q <= 8'd0;
      bad_run_q  <= 4'd0;
      locked_q   <= 1'b0;
      bit_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_cnt_q <= fill_cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_run_q  <= bad_run_d;
      locked_q   <= locked_d;
      bit_err_q  <= bit_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign bit_err   = bit_err_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

`ifdef PRBS9_CHECKER_HEX_EN
  // Active-low gfedcba segment code for one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign hex_high = seg7(err_cnt_q[7:4]);
  assign hex_low  = seg7(err_cnt_q[3:0]);
`else
  assign hex_high = 7'h7F;
  assign hex_low  = 7'h7F;
`endif

endmodule

// File: tb/tb_prbs9_checker.sv
// Self-checking bench for prbs9_checker: directed scenarios plus a randomized run,
// compared every cycle against a queue-based behavioural model of the stream checker.
module tb_prbs9_checker;
  localparam int LOCK_T = 16;
  localparam int LOSS_T = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       clr_err;
  logic       locked;
  logic       bit_err;
  logic [7:0] err_cnt;
  logic [6:0] hex_high;
  logic [6:0] hex_low;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  prbs9_checker #(.LOCK_THRESH(LOCK_T), .LOSS_THRESH(LOSS_T)) dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .clr_err(clr_err),
    .locked(locked), .bit_err(bit_err), .err_cnt(err_cnt),
    .hex_high(hex_high), .hex_low(hex_low), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit         s_arr[8192];   // clean reference stream from the seed 1,0,0,0,0,0,0,0,0
  int         pos;           // next stream index to transmit
  logic [6:0] seg_tab[16];
  logic [6:0] hex0, hex1, hexf;

  // ---------------- behavioural model ----------------
  bit m_hist[$];   // last accepted bits, oldest first
  int m_run;
  bit m_locked;
  bit m_biterr;
  int m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_hex(input int nib);
    logic [6:0] v;
    v = seg_tab[nib[3:0]];
`ifndef PRBS9_CHECKER_HEX_EN
    v = 7'h7F;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_run    = 0;
    m_locked = 0;
    m_biterr = 0;
    m_err    = 0;
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit pred;
    bit nz;
    m_biterr = 0;
    if (v) begin
      if (m_hist.size() < 9) begin
        m_hist.push_back(b);
      end else begin
        pred = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
        nz = 0;
        foreach (m_hist[k]) if (m_hist[k]) nz = 1;
        if (!m_locked) begin
          if (b == pred && nz) m_run++; else m_run = 0;
          m_hist.push_back(b);
          void'(m_hist.pop_front());
          if (m_run == LOCK_T) begin m_locked = 1; m_run = 0; end
        end else begin
          m_hist.push_back(pred);
          void'(m_hist.pop_front());
          if (b != pred) begin
            m_biterr = 1;
            if (m_err < 255) m_err++;
            m_run++;
            if (m_run == LOSS_T) begin m_locked = 0; m_run = 0; end
          end else begin
            m_run = 0;
          end
        end
      end
    end
    if (c) m_err = 0;
  endtask

  task automatic compare_all();
    chk("locked",   locked,   m_locked);
    chk("bit_err",  bit_err,  m_biterr);
    chk("err_cnt",  err_cnt,  m_err);
    chk("hex_high", hex_high, exp_hex(m_err >> 4));
    chk("hex_low",  hex_low,  exp_hex(m_err & 15));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit b, input bit v, input bit c);
    in_bit   = b;
    in_valid = v;
    clr_err  = c;
    @(posedge clk);
    model_step(b, v, c);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic send(input bit flip, input bit v, input bit c);
    bit b;
    b = 1'($urandom_range(0, 1));
    if (v) begin
      b = s_arr[pos] ^ flip;
      pos++;
    end
    cycle(b, v, c);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
    reset = 1'b0;
    pos   = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int first_lock;
    int cnt;
    bit any_lock;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    hex0 = 7'h40; hex1 = 7'h79; hexf = 7'h0E;
`ifndef PRBS9_CHECKER_HEX_EN
    hex0 = 7'h7F; hex1 = 7'h7F; hexf = 7'h7F;
`endif
    for (int m = 0; m < 9; m++) s_arr[m] = (m == 0);
    for (int m = 9; m < 8192; m++) s_arr[m] = s_arr[m-9] ^ s_arr[m-7] ^ s_arr[m-6] ^ s_arr[m-5];

    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_locked",   locked,   0);
    chk("rst_bit_err",  bit_err,  0);
    chk("rst_err_cnt",  err_cnt,  0);
    chk("rst_hex_high", hex_high, hex0);
    chk("rst_hex_low",  hex_low,  hex0);
    reset = 1'b0;
    pos   = 0;

    // Clean stream: lock visible after the 25th bit (index 24)
    first_lock = -1;
    for (int i = 0; i < 40; i++) begin
      send(0, 1, 0);
      if (locked && first_lock < 0) first_lock = i;
    end
    chk("lock_bit_index", first_lock, 24);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_hex_low", hex_low, hex0);

    // Single inverted bit at n = 40
    send(1, 1, 0);
    chk("single_bit_err", bit_err, 1);
    chk("single_err_cnt", err_cnt, 1);
    chk("single_locked",  locked,  1);
    chk("single_hex_low", hex_low, hex1);
    send(0, 1, 0);
    chk("single_pulse_end", bit_err, 0);
    repeat (18) send(0, 1, 0);

    // Four consecutive errors drop lock; relock 16 clean bits later
    send(0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      send(1, 1, 0);
      if (k == 2) chk("burst3_still_locked", locked, 1);
    end
    chk("loss_locked", locked, 0);
    chk("loss_err_cnt", err_cnt, 4);
    cnt = 0;
    while (!locked && cnt < 40) begin
      send(0, 1, 0);
      cnt++;
    end
    chk("relock_bits", cnt, 16);

    // Saturation via 3-bit bursts, then clear with a simultaneous error
    for (int b = 0; b < 100; b++) begin
      repeat (3) send(1, 1, 0);
      send(0, 1, 0);
    end
    chk("sat_err_cnt",  err_cnt,  255);
    chk("sat_locked",   locked,   1);
    chk("sat_hex_high", hex_high, hexf);
    chk("sat_hex_low",  hex_low,  hexf);
    send(1, 1, 1);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_bit_err", bit_err, 1);
    send(0, 1, 0);

    // All-zero stream never locks
    do_reset();
    any_lock = 0;
    repeat (100) begin
      cycle(0, 1, 0);
      if (locked) any_lock = 1;
    end
    chk("zero_never_locked", any_lock, 0);
    chk("zero_err_cnt", err_cnt, 0);

    // in_valid on alternate cycles: lock counts valid bits, not cycles
    do_reset();
    first_lock = -1;
    for (int i = 0; i < 60; i++) begin
      send(0, (i % 2) == 0, 0);
      if (locked && first_lock < 0) first_lock = i;
    end
    chk("gap_lock_cycle", first_lock, 48);

    // Asynchronous reset while locked and with a pending error pulse
    send(1, 1, 0);
    chk("pre_rst_bit_err", bit_err, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_locked",   locked,   0);
    chk("async_bit_err",  bit_err,  0);
    chk("async_err_cnt",  err_cnt,  0);
    chk("async_hex_high", hex_high, hex0);
    chk("async_hex_low",  hex_low,  hex0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    pos   = 0;

    // Randomized: valid gaps, sparse bit flips, occasional clears
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      send($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
